// File: rtl/cd_dma_engine.sv
// DMA engine for the CD system controller: register port, 68K bus arbitration and
// word copy/fill over a ready-handshaked memory port, with a sticky completion IRQ.
module cd_dma_engine #(
  parameter int ADDR_W    = 24,
  parameter int CNT_W     = 24,
  parameter int BURST_LEN = 64
) (
  input  logic              CLK_68KCLK,
  input  logic              RESET,
  input  logic              REG_WR,
  input  logic [2:0]        REG_SEL,
  input  logic [15:0]       REG_DATA,
  input  logic              IRQ_ACK,
  output logic              BUS_REQ,
  input  logic              BUS_ACK,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  output logic              MEM_WR,
  output logic [15:0]       MEM_DOUT,
  input  logic [15:0]       MEM_DIN,
  input  logic              MEM_READY,
  output logic              BUSY,
  output logic              DONE,
  output logic              IRQ
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ARB = 3'd1, S_RD = 3'd2, S_WR = 3'd3,
    S_NEXT = 3'd4, S_REL = 3'd5, S_END = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_LEN);

  state_t              state_q;
  logic [ADDR_W-1:0]   src_reg_q, dst_reg_q, src_q, dst_q, mem_addr_q;
  logic [CNT_W-1:0]    cnt_reg_q, cnt_q, burst_q;
  logic [15:0]         value_q, mem_dout_q;
  logic                mode_q, abort_q, bus_req_q, mem_rd_q, mem_wr_q;
  logic                busy_q, done_q, irq_q;

  logic [ADDR_W-1:0]   src_d, dst_d;
  logic [CNT_W-1:0]    cnt_d, burst_d;
  logic                ctrl_wr, abort_now;

  always_comb begin
    src_d     = src_q + ADDR_W'(2);
    dst_d     = dst_q + ADDR_W'(2);
    cnt_d     = (cnt_q == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : cnt_q - CNT_W'(1);
    burst_d   = burst_q + CNT_W'(1);
    ctrl_wr   = REG_WR && (REG_SEL == 3'd0);
    abort_now = abort_q || (ctrl_wr && REG_DATA[2]);
  end

  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      src_reg_q  <= {ADDR_W{1'b0}};
      dst_reg_q  <= {ADDR_W{1'b0}};
      src_q      <= {ADDR_W{1'b0}};
      dst_q      <= {ADDR_W{1'b0}};
      mem_addr_q <= {ADDR_W{1'b0}};
      cnt_reg_q  <= {CNT_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      burst_q    <= {CNT_W{1'b0}};
      value_q    <= 16'h0000;
      mem_dout_q <= 16'h0000;
      mode_q     <= 1'b0;
      abort_q    <= 1'b0;
      bus_req_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (IRQ_ACK) irq_q <= 1'b0;
      if (state_q != S_IDLE && ctrl_wr && REG_DATA[2]) abort_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (REG_WR) begin
            case (REG_SEL)
              3'd0: begin
                mode_q <= REG_DATA[1];
                if (REG_DATA[0]) begin
                  src_q      <= src_reg_q;
                  dst_q      <= dst_reg_q;
                  cnt_q      <= cnt_reg_q;
                  burst_q    <= {CNT_W{1'b0}};
                  mem_dout_q <= value_q;
                  busy_q     <= 1'b1;
                  if (cnt_reg_q == {CNT_W{1'b0}}) begin
                    state_q <= S_END;
                    done_q  <= 1'b1;
                    irq_q   <= 1'b1;
                  end else begin
                    state_q   <= S_ARB;
                    bus_req_q <= 1'b1;
                  end
                end
              end
              3'd1: src_reg_q[ADDR_W-1:16] <= REG_DATA[ADDR_W-17:0];
              3'd2: src_reg_q[15:0]        <= {REG_DATA[15:1], 1'b0};
              3'd3: dst_reg_q[ADDR_W-1:16] <= REG_DATA[ADDR_W-17:0];
              3'd4: dst_reg_q[15:0]        <= {REG_DATA[15:1], 1'b0};
              3'd5: value_q                <= REG_DATA;
              3'd6: cnt_reg_q[CNT_W-1:16]  <= REG_DATA[CNT_W-17:0];
              3'd7: cnt_reg_q[15:0]        <= REG_DATA;
              default: value_q <= value_q;
            endcase
          end
        end
        S_ARB: begin
          if (abort_now) begin
            state_q   <= S_END;
            bus_req_q <= 1'b0;
            done_q    <= 1'b1;
            irq_q     <= 1'b1;
          end else if (BUS_ACK) begin
            state_q    <= mode_q ? S_RD : S_WR;
            mem_addr_q <= mode_q ? src_q : dst_q;
            mem_rd_q   <= mode_q;
            mem_wr_q   <= !mode_q;
          end
        end
        // A strobe low in RD/WR means the access still waits for the bus grant.
        S_RD: begin
          if (!mem_rd_q) begin
            if (BUS_ACK) mem_rd_q <= 1'b1;
          end else if (MEM_READY) begin
            mem_rd_q   <= 1'b0;
            mem_dout_q <= MEM_DIN;
            mem_addr_q <= dst_q;
            mem_wr_q   <= BUS_ACK;
            state_q    <= S_WR;
          end
        end
        S_WR: begin
          if (!mem_wr_q) begin
            if (BUS_ACK) mem_wr_q <= 1'b1;
          end else if (MEM_READY) begin
            mem_wr_q <= 1'b0;
            state_q  <= S_NEXT;
          end
        end
        S_NEXT: begin
          dst_q <= dst_d;
          if (mode_q) src_q <= src_d;
          cnt_q <= cnt_d;
          if (cnt_d == {CNT_W{1'b0}} || abort_now) begin
            state_q   <= S_END;
            bus_req_q <= 1'b0;
            done_q    <= 1'b1;
            irq_q     <= 1'b1;
          end else if (BURST_LEN != 0 && burst_d == BURST_C) begin
            state_q   <= S_REL;
            bus_req_q <= 1'b0;
            burst_q   <= {CNT_W{1'b0}};
          end else begin
            burst_q    <= burst_d;
            state_q    <= mode_q ? S_RD : S_WR;
            mem_addr_q <= mode_q ? src_d : dst_d;
            mem_rd_q   <= mode_q && BUS_ACK;
            mem_wr_q   <= !mode_q && BUS_ACK;
          end
        end
        S_REL: begin
          if (abort_now) begin
            state_q <= S_END;
            done_q  <= 1'b1;
            irq_q   <= 1'b1;
          end else begin
            state_q   <= S_ARB;
            bus_req_q <= 1'b1;
          end
        end
        S_END: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          bus_req_q <= 1'b0;
          mem_rd_q  <= 1'b0;
          mem_wr_q  <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign BUS_REQ  = bus_req_q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_RD   = mem_rd_q;
  assign MEM_WR   = mem_wr_q;
  assign MEM_DOUT = mem_dout_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign IRQ      = irq_q;

endmodule

// File: tb/tb_cd_dma_engine.sv
// Scoreboard bench for cd_dma_engine: stimulus queues expected memory accesses,
// a negedge monitor pops and compares them as the engine completes each access.
module tb_cd_dma_engine;

  logic        clk = 1'b0;
  logic        rst, reg_wr, irq_ack;
  logic [2:0]  reg_sel;
  logic [15:0] reg_data;
  logic        bus_req, bus_ack = 1'b0;
  logic [23:0] mem_addr;
  logic        mem_rd, mem_wr, mem_ready;
  logic [15:0] mem_dout, mem_din;
  logic        busy, done, irq;

  typedef struct packed {
    logic        is_wr;
    logic [23:0] addr;
    logic [15:0] data;
  } acc_t;

  acc_t        sb[$];
  int          drops[$];
  int          compared = 0, mismatched = 0;
  int          ack_delay = 0, mem_wait = 0, ack_cnt = 0, wcnt = 0;
  int          rd_cnt = 0, rd_base = 0, done_cnt = 0, wr_cnt = 0;
  logic        bus_req_prev = 1'b0;
  logic [15:0] rd_data [0:3];

  cd_dma_engine #(.ADDR_W(24), .CNT_W(24), .BURST_LEN(2)) dut (
    .CLK_68KCLK(clk), .RESET(rst), .REG_WR(reg_wr), .REG_SEL(reg_sel),
    .REG_DATA(reg_data), .IRQ_ACK(irq_ack), .BUS_REQ(bus_req), .BUS_ACK(bus_ack),
    .MEM_ADDR(mem_addr), .MEM_RD(mem_rd), .MEM_WR(mem_wr), .MEM_DOUT(mem_dout),
    .MEM_DIN(mem_din), .MEM_READY(mem_ready), .BUSY(busy), .DONE(done), .IRQ(irq)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push_acc(input logic w, input logic [23:0] a, input logic [15:0] d);
    acc_t e;
    e.is_wr = w;
    e.addr  = a;
    e.data  = d;
    sb.push_back(e);
  endfunction

  // Bus arbiter: grants ack_delay cycles after the request, drops with it.
  always @(posedge clk) begin
    if (bus_req !== 1'b1) begin
      ack_cnt <= 0;
      bus_ack <= 1'b0;
    end else if (ack_cnt >= ack_delay) bus_ack <= 1'b1;
    else ack_cnt <= ack_cnt + 1;
  end

  // Memory: MEM_READY after mem_wait cycles, read data from a small table.
  always @(posedge clk) begin
    if ((mem_rd === 1'b1 || mem_wr === 1'b1) && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_rd === 1'b1 && mem_ready) rd_cnt <= rd_cnt + 1;
  end
  assign mem_ready = (mem_rd === 1'b1 || mem_wr === 1'b1) && (wcnt >= mem_wait);
  assign mem_din   = rd_data[(rd_cnt - rd_base) & 3];

  always @(negedge clk) begin
    acc_t e;
    if (done === 1'b1) done_cnt++;
    if (bus_req_prev === 1'b1 && bus_req === 1'b0 && busy === 1'b1) drops.push_back(wr_cnt);
    bus_req_prev = bus_req;
    if (mem_rd === 1'b1 || mem_wr === 1'b1) begin
      chk("rd_wr_overlap", {31'd0, mem_rd & mem_wr}, 32'd0);
      chk("strobe_ack", {31'd0, bus_ack}, 32'd1);
    end
    if (mem_ready) begin
      if (mem_wr === 1'b1) wr_cnt++;
      if (sb.size() == 0) chk("unexpected_access", sb.size(), 32'd1);
      else begin
        e = sb.pop_front();
        chk("acc_kind", {31'd0, mem_wr}, {31'd0, e.is_wr});
        chk("acc_addr", {8'd0, mem_addr}, {8'd0, e.addr});
        if (e.is_wr) chk("acc_data", {16'd0, mem_dout}, {16'd0, e.data});
      end
    end
  end

  task automatic reg_write(input logic [2:0] sel, input logic [15:0] d);
    @(negedge clk);
    reg_wr = 1'b1; reg_sel = sel; reg_data = d;
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  task automatic prog(input logic [23:0] src, input logic [23:0] dst,
                      input logic [15:0] val, input logic [23:0] cnt);
    reg_write(3'd1, {8'h00, src[23:16]});
    reg_write(3'd2, src[15:0]);
    reg_write(3'd3, {8'h00, dst[23:16]});
    reg_write(3'd4, dst[15:0]);
    reg_write(3'd5, val);
    reg_write(3'd6, {8'h00, cnt[23:16]});
    reg_write(3'd7, cnt[15:0]);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(name, {31'd0, seen}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic irq_clear();
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
  endtask

  task automatic wait_wr(input string name, input logic [23:0] addr, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_wr === 1'b1 && mem_addr == addr) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int db, dr, wb;
    rst = 1'b1; reg_wr = 1'b0; reg_sel = 3'd0; reg_data = 16'h0000; irq_ack = 1'b0;
    rd_data[0] = 16'h1111; rd_data[1] = 16'h2222; rd_data[2] = 16'h3333; rd_data[3] = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_busy_done_irq", {29'd0, busy, done, irq}, 32'd0);
    chk("rst_addr", {8'd0, mem_addr}, 32'd0);
    rst = 1'b0;

    // FILL 4 words at 0x100000
    ack_delay = 3; mem_wait = 0;
    prog(24'h000000, 24'h100000, 16'hA5A5, 24'd4);
    for (int i = 0; i < 4; i++) push_acc(1'b1, 24'h100000 + 24'(2 * i), 16'hA5A5);
    db = done_cnt;
    reg_write(3'd0, 16'h0001);
    chk("fill_busy_rise", {31'd0, busy}, 32'd1);
    wait_done("fill_done", 200);
    chk("fill_done_pulses", done_cnt - db, 32'd1);
    chk("fill_irq", {31'd0, irq}, 32'd1);
    chk("fill_idle", {30'd0, bus_req, busy}, 32'd0);
    chk("fill_sb_empty", sb.size(), 32'd0);
    irq_clear();
    chk("irq_ack_clear", {31'd0, irq}, 32'd0);

    // COPY 3 words 0x200 -> 0xE00000
    ack_delay = 1;
    rd_base = rd_cnt;
    prog(24'h000200, 24'hE00000, 16'h0000, 24'd3);
    push_acc(1'b0, 24'h000200, 16'h0000); push_acc(1'b1, 24'hE00000, 16'h1111);
    push_acc(1'b0, 24'h000202, 16'h0000); push_acc(1'b1, 24'hE00002, 16'h2222);
    push_acc(1'b0, 24'h000204, 16'h0000); push_acc(1'b1, 24'hE00004, 16'h3333);
    reg_write(3'd0, 16'h0003);
    wait_done("copy_done", 200);
    chk("copy_sb_empty", sb.size(), 32'd0);
    irq_clear();

    // CNT=0: one-cycle BUSY, DONE right away, no bus request
    prog(24'h000200, 24'h000000, 16'h0000, 24'd0);
    reg_write(3'd0, 16'h0001);
    chk("cnt0_first", {28'd0, busy, done, irq, bus_req}, 32'hE);
    @(negedge clk);
    chk("cnt0_second", {29'd0, busy, done, bus_req}, 32'd0);
    irq_clear();

    // Address wrap at top of memory
    prog(24'h000200, 24'hFFFFFE, 16'h5A5A, 24'd2);
    push_acc(1'b1, 24'hFFFFFE, 16'h5A5A); push_acc(1'b1, 24'h000000, 16'h5A5A);
    reg_write(3'd0, 16'h0001);
    wait_done("wrap_done", 200);
    chk("wrap_sb_empty", sb.size(), 32'd0);

    // Burst release after words 2 and 4, final drop after word 5
    prog(24'h000200, 24'h000040, 16'h1234, 24'd5);
    for (int i = 0; i < 5; i++) push_acc(1'b1, 24'h000040 + 24'(2 * i), 16'h1234);
    dr = drops.size(); wb = wr_cnt;
    reg_write(3'd0, 16'h0001);
    wait_done("burst_done", 300);
    chk("burst_drop_count", drops.size() - dr, 32'd3);
    if (drops.size() - dr == 3) begin
      chk("burst_drop1", drops[dr] - wb, 32'd2);
      chk("burst_drop2", drops[dr + 1] - wb, 32'd4);
      chk("burst_drop3", drops[dr + 2] - wb, 32'd5);
    end
    chk("burst_sb_empty", sb.size(), 32'd0);
    irq_clear();

    // ABORT during the 3rd word of a 10-word fill, 2-cycle memory
    mem_wait = 2;
    prog(24'h000200, 24'h000100, 16'hBEEF, 24'd10);
    for (int i = 0; i < 3; i++) push_acc(1'b1, 24'h000100 + 24'(2 * i), 16'hBEEF);
    db = done_cnt;
    reg_write(3'd0, 16'h0001);
    wait_wr("abort_reach_w3", 24'h000104, 200);
    reg_write(3'd2, 16'h1234);
    reg_write(3'd0, 16'h0004);
    wait_done("abort_done", 100);
    chk("abort_done_pulses", done_cnt - db, 32'd1);
    chk("abort_cnt_left", {8'd0, dut.cnt_q}, 32'd7);
    chk("abort_src_ignored", {8'd0, dut.src_reg_q}, 32'h000200);
    chk("abort_irq", {31'd0, irq}, 32'd1);
    chk("abort_sb_empty", sb.size(), 32'd0);

    // RESET while a write is pending
    mem_wait = 5;
    prog(24'h000200, 24'h000200, 16'h7777, 24'd3);
    reg_write(3'd0, 16'h0001);
    wait_wr("rst_reach_wr", 24'h000200, 100);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_outputs", {28'd0, bus_req, mem_wr, busy, irq}, 32'd0);
    chk("rstmid_dst_reg", {8'd0, dut.dst_reg_q}, 32'd0);
    chk("rstmid_cnt_reg", {8'd0, dut.cnt_reg_q}, 32'd0);
    chk("rstmid_value", {16'd0, dut.value_q}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cd_dma_engine.md
Name: cd_dma_engine

Overview:
Parametrised DMA engine for the CD system controller. It runs the DMA that the register block only latches. The 68K programs source, destination, fill value, word count and mode through a word-wide register port, then starts a transfer. The engine requests the 68K bus, performs 16-bit word transfers over a ready-handshaked memory port in copy or fill mode, and signals completion with a sticky IRQ. It sits between the FF00xx register decode and the memory arbiter.

Parameters:
ADDR_W, 24, byte-address width of SRC/DST (bit 0 always 0; addresses wrap modulo 2^ADDR_W)
CNT_W, 24, word-count width (max 2^CNT_W-1 words)
BURST_LEN, 64, words moved per bus tenure before BUS_REQ is released for one cycle; 0 = hold bus for the whole transfer

Ports:
CLK_68KCLK  in  1  sole clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
REG_WR  in  1  one-cycle register write strobe
REG_SEL  in  3  register index: 0 CTRL, 1 SRC_HI, 2 SRC_LO, 3 DST_HI, 4 DST_LO, 5 VALUE, 6 CNT_HI, 7 CNT_LO
REG_DATA  in  16  write data; HI registers use the low ADDR_W-16 (or CNT_W-16) bits
IRQ_ACK  in  1  clears IRQ
BUS_REQ  out  1  bus request (68K BR)
BUS_ACK  in  1  bus granted (BG/BGACK combined)
MEM_ADDR  out  ADDR_W  byte address of current access
MEM_RD  out  1  read request, held until MEM_READY
MEM_WR  out  1  write request, held until MEM_READY
MEM_DOUT  out  16  write data
MEM_DIN  in  16  read data, valid with MEM_READY
MEM_READY  in  1  access complete
BUSY  out  1  high from start until return to IDLE
DONE  out  1  one-cycle pulse on completion or abort
IRQ  out  1  sticky completion flag

Behaviour:
- Reset: all outputs 0; state IDLE; all registers 0; mode FILL.
- CTRL bits: [0] START, [1] MODE (0 FILL, 1 COPY), [2] ABORT. START and ABORT are self-clearing.
- Register writes are accepted only in IDLE. While BUSY, only a CTRL write with ABORT=1 has effect; all other writes are ignored.
- START in IDLE latches working copies of SRC, DST and CNT. BUSY rises on the next edge.
- START with CNT=0: DONE pulses on the next edge, IRQ is set, BUS_REQ never asserts, BUSY is high for exactly 1 cycle.
- States:
  - IDLE.
  - ARB: BUS_REQ=1; wait for BUS_ACK.
  - RD (COPY only): MEM_RD=1, MEM_ADDR=src; on MEM_READY capture MEM_DIN.
  - WR: MEM_WR=1, MEM_ADDR=dst, MEM_DOUT = VALUE (FILL) or captured data (COPY); wait for MEM_READY.
  - NEXT: dst+=2; src+=2 (COPY only); cnt-=1; burst counter +1.
  - END.
- Transitions:
  - ARB->RD/WR in the cycle after BUS_ACK is seen.
  - NEXT->END when cnt reaches 0.
  - NEXT->REL when BURST_LEN!=0 and the burst counter reaches BURST_LEN.
  - REL: BUS_REQ=0 for one cycle, burst counter cleared, then ARB.
  - Otherwise NEXT->RD (COPY) or WR (FILL) with BUS_REQ still held.
- END: BUS_REQ=0, DONE=1 for one cycle, IRQ=1, then IDLE.
- BUS_REQ stays high from ARB through NEXT. If BUS_ACK drops mid-transfer, the engine stalls in its current state. An access already issued stays asserted until MEM_READY.
- ABORT: takes effect at the next NEXT boundary or in ARB/REL. The access in flight completes. The engine then goes to END (DONE pulse, IRQ set) with cnt holding the remaining words minus the completed one.
- Address arithmetic: unsigned, modulo 2^ADDR_W; bit 0 forced 0. Counter never underflows.
- MEM_RD and MEM_WR are never high together and never asserted without BUS_ACK.
- IRQ: set in END, cleared by IRQ_ACK. If both occur in the same cycle, set wins.
- RESET mid-transfer: next edge drops BUS_REQ, MEM_RD and MEM_WR to 0 and returns to IDLE. The memory side must tolerate an abandoned access.
- Throughput with zero-wait memory: FILL = 2 cycles/word, COPY = 3 cycles/word, plus ARB latency and 2 cycles per REL.

Test Plan:
- FILL: DST=0x100000, VALUE=0xA5A5, CNT=4, START, BUS_ACK after 3 cycles, MEM_READY immediate -> writes to 0x100000/02/04/06 all 0xA5A5, DONE one pulse, IRQ=1, BUS_REQ low afterwards.
- COPY: SRC=0x000200, DST=0xE00000, CNT=3, MEM_DIN=0x1111/0x2222/0x3333 -> reads alternate with writes in that order; read addrs 0x200/202/204, write addrs 0xE00000/02/04 with matching data.
- Boundaries: CNT=0 START -> DONE on next edge, no BUS_REQ. DST=0xFFFFFE, CNT=2 -> second write to 0x000000.
- BURST_LEN=2, CNT=5 FILL -> BUS_REQ drops one cycle after words 2 and 4, re-arbitrates, 5 writes total.
- ABORT during the 3rd word of CNT=10 FILL with 2-cycle MEM_READY delay -> 3rd write completes, no 4th write, DONE pulse, internal cnt=7. A SRC write while BUSY is ignored.
- RESET asserted while MEM_WR is pending -> next edge: BUS_REQ=0, MEM_WR=0, BUSY=0, IRQ=0, registers cleared.
